// File: rtl/rx_char_sched.sv
// Round-robin merge of keyboard and UART RX byte strobes into one valid/ready
// character stream, with a per-source FIFO and an optional idle gap per byte.
module rx_char_sched #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4,
  parameter int GAPW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d0,
  input  logic       d0v,
  input  logic [7:0] d1,
  input  logic       d1v,
  output logic [7:0] od,
  output logic       odv,
  input  logic       odr,
  output logic       osrc,
  output logic       ovf0,
  output logic       ovf1,
  output logic [7:0] drop0,
  output logic [7:0] drop1,
  input  logic       clr_stats,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [7:0]        mem_q [2][DEPTH];
  logic [1:0][AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic [1:0][7:0]   drop_q, drop_d;
  logic [1:0]        ovf_q, ovf_d;
  logic [1:0][7:0]   din;
  logic [1:0]        dv, empty, full, push, pop, drop_ev;
  logic              any, grant;
  logic [7:0]        head;

  state_t            state_q;
  logic [7:0]        od_q;
  logic              odv_q, osrc_q, last_q;
  logic [GAPW-1:0]   gap_q;

  assign din = {d1, d0};
  assign dv  = {d1v, d0v};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      empty[s] = (wp_q[s] == rp_q[s]);
      full[s]  = (wp_q[s][AW] != rp_q[s][AW]) && (wp_q[s][AW-1:0] == rp_q[s][AW-1:0]);
    end
    any = !empty[0] || !empty[1];
    // With both sources pending, alternate away from the last winner
    if (!empty[0] && !empty[1]) grant = ~last_q;
    else                        grant = empty[0];
    head = mem_q[grant][rp_q[grant][AW-1:0]];
    for (int s = 0; s < 2; s++) begin
      pop[s]     = (state_q == IDLE) && any && (grant == s[0]);
      // A pop in the same cycle frees the slot for a write into a full FIFO
      push[s]    = dv[s] && (!full[s] || pop[s]);
      drop_ev[s] = dv[s] && !push[s];
      wp_d[s]    = wp_q[s] + {{AW{1'b0}}, push[s]};
      rp_d[s]    = rp_q[s] + {{AW{1'b0}}, pop[s]};
      if (clr_stats) begin
        drop_d[s] = 8'd0;
        ovf_d[s]  = 1'b0;
      end else begin
        drop_d[s] = (drop_ev[s] && drop_q[s] != 8'hFF) ? drop_q[s] + 8'd1 : drop_q[s];
        ovf_d[s]  = ovf_q[s] | drop_ev[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++)
      if (push[s]) mem_q[s][wp_q[s][AW-1:0]] <= din[s];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      drop_q <= '0;
      ovf_q  <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      od_q    <= 8'd0;
      odv_q   <= 1'b0;
      osrc_q  <= 1'b0;
      last_q  <= 1'b1;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            od_q    <= head;
            osrc_q  <= grant;
            odv_q   <= 1'b1;
            last_q  <= grant;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (odr) begin
            odv_q <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              gap_q   <= GAPW'(GAP_CYCLES);
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          gap_q <= gap_q - 1'b1;
          if (gap_q == GAPW'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign od    = od_q;
  assign odv   = odv_q;
  assign osrc  = osrc_q;
  assign ovf0  = ovf_q[0];
  assign ovf1  = ovf_q[1];
  assign drop0 = drop_q[0];
  assign drop1 = drop_q[1];
  assign busy  = (state_q != IDLE) || any;

endmodule

// File: tb/tb_rx_char_sched.sv
// Directed bench for rx_char_sched: latency, round-robin order, backpressure,
// overflow statistics, FIFO wrap, drop saturation and mid-transfer reset.
module tb_rx_char_sched;

  logic       clk = 1'b0;
  logic       reset, d0v, d1v, odr, clr_stats;
  logic [7:0] d0, d1;
  logic [7:0] od, drop0, drop1;
  logic       odv, osrc, ovf0, ovf1, busy;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [8:0] outq[$];
  int         tq[$];

  rx_char_sched #(.DEPTH(8), .GAP_CYCLES(4), .GAPW(8)) dut (
    .clk(clk), .reset(reset), .d0(d0), .d0v(d0v), .d1(d1), .d1v(d1v),
    .od(od), .odv(odv), .odr(odr), .osrc(osrc), .ovf0(ovf0), .ovf1(ovf1),
    .drop0(drop0), .drop1(drop1), .clr_stats(clr_stats), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record each completed handshake as {osrc, od}
  always @(negedge clk) begin
    if (!reset && odv && odr) begin
      outq.push_back({osrc, od});
      tq.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    d0v = 1'b0; d1v = 1'b0; clr_stats = 1'b0;
    tick();
    reset = 1'b0;
    outq.delete();
    tq.delete();
  endtask

  task automatic strobe(input bit s, input logic [7:0] v);
    if (s) begin d1 = v; d1v = 1'b1; end
    else   begin d0 = v; d0v = 1'b1; end
    tick();
    d0v = 1'b0; d1v = 1'b0;
  endtask

  task automatic wait_n(input int n, input int budget);
    int k = 0;
    while (outq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("wait_out", outq.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic expect_out(input string tag, input int i, input logic [8:0] exp);
    if (i < outq.size()) check(tag, outq[i], exp);
    else                 check(tag, 32'hDEAD, exp);
  endtask

  initial begin
    d0 = 8'd0; d1 = 8'd0; odr = 1'b0;
    do_reset();
    check("rst_od", od, 0);
    check("rst_odv", odv, 0);
    check("rst_osrc", osrc, 0);
    check("rst_ovf", {ovf1, ovf0}, 0);
    check("rst_drop", {drop1, drop0}, 0);
    check("rst_busy", busy, 0);

    // Single byte latency and gap length
    odr = 1'b1;
    strobe(1'b0, 8'h41);
    check("single_e1_odv", odv, 0);
    tick();
    check("single_e2_odv", odv, 1);
    check("single_od", od, 8'h41);
    check("single_osrc", osrc, 0);
    tick();
    check("single_e3_odv", odv, 0);
    repeat (3) tick();
    check("single_busy_gap", busy, 1);
    tick();
    check("single_busy_done", busy, 0);

    // Simultaneous strobes
    do_reset();
    odr = 1'b1;
    d0 = 8'h61; d1 = 8'h1B; d0v = 1'b1; d1v = 1'b1;
    tick();
    d0v = 1'b0; d1v = 1'b0;
    wait_n(2, 40);
    expect_out("simul_first", 0, {1'b0, 8'h61});
    expect_out("simul_second", 1, {1'b1, 8'h1B});
    if (tq.size() >= 2) check("simul_spacing", tq[1] - tq[0], 6);

    // Fairness with both queues loaded
    do_reset();
    odr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d0 = 8'h10 + 8'(i); d1 = 8'h20 + 8'(i); d0v = 1'b1; d1v = 1'b1;
      tick();
    end
    d0v = 1'b0; d1v = 1'b0;
    wait_n(8, 100);
    for (int i = 0; i < 8; i++)
      expect_out("fair_order", i, (i % 2) ? {1'b1, 8'h20 + 8'(i / 2)} : {1'b0, 8'h10 + 8'(i / 2)});

    // Backpressure and overflow on source 1
    do_reset();
    odr = 1'b0;
    for (int i = 0; i < 11; i++) begin
      strobe(1'b1, 8'h30 + 8'(i));
      if (i >= 1) check("bp_od_stable", od, 8'h30);
    end
    check("bp_odv_held", odv, 1);
    check("bp_drop1", drop1, 2);
    check("bp_ovf1", ovf1, 1);
    check("bp_ovf0", ovf0, 0);
    odr = 1'b1;
    wait_n(9, 200);
    for (int i = 0; i < 9; i++) expect_out("bp_order", i, {1'b1, 8'h30 + 8'(i)});
    wait_idle(40);
    check("bp_no_extra", outq.size(), 9);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("bp_clr_drop1", drop1, 0);
    check("bp_clr_ovf1", ovf1, 0);

    // Pointer wrap: three bursts of DEPTH bytes through source 0
    do_reset();
    odr = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) strobe(1'b0, 8'h80 + 8'(b * 8 + i));
      wait_idle(100);
    end
    check("wrap_count", outq.size(), 24);
    for (int i = 0; i < 24; i++) expect_out("wrap_order", i, {1'b0, 8'h80 + 8'(i)});
    check("wrap_drop0", drop0, 0);

    // Drop counter saturation on source 0
    do_reset();
    odr = 1'b0;
    for (int i = 0; i < 19; i++) strobe(1'b0, 8'(i));
    check("sat_drop0_10", drop0, 10);
    check("sat_ovf0", ovf0, 1);
    for (int i = 0; i < 290; i++) strobe(1'b0, 8'(i));
    check("sat_drop0_255", drop0, 255);
    clr_stats = 1'b1;
    strobe(1'b0, 8'hEE);
    clr_stats = 1'b0;
    check("sat_clr_wins", drop0, 0);
    check("sat_clr_ovf0", ovf0, 0);

    // Reset while a byte is pending with three more queued
    do_reset();
    odr = 1'b0;
    for (int i = 0; i < 4; i++) strobe(1'b0, 8'h50 + 8'(i));
    check("mid_odv_before", odv, 1);
    check("mid_busy_before", busy, 1);
    do_reset();
    check("mid_odv_after", odv, 0);
    check("mid_busy_after", busy, 0);
    check("mid_od_after", od, 0);
    odr = 1'b1;
    strobe(1'b1, 8'h77);
    wait_n(1, 20);
    expect_out("mid_next", 0, {1'b1, 8'h77});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_char_sched.md
Name: rx_char_sched

Overview:
- Buffered round-robin scheduler that merges two 8-bit character sources into one ANSI-decoder input stream.
- Source 0 is the PS/2 keyboard ASCII strobe; source 1 is the UART RX byte strobe.
- Each source has its own FIFO, so simultaneous or bursty strobes are not lost.
- The output uses a valid/ready handshake, with an optional enforced idle gap so the downstream decoder/VGA command path can finish each character.

Parameters:
- DEPTH, 8, entries per source FIFO; power of 2, minimum 2.
- GAP_CYCLES, 4, idle cycles inserted after each accepted output byte; 0 means back-to-back.
- GAPW, 8, width of the gap counter; GAP_CYCLES must be less than 2^GAPW.

Ports:
- clk  in  1  system clock (24 MHz pixel/bit clock domain)
- reset  in  1  synchronous active-high reset
- d0  in  8  source 0 (keyboard) data
- d0v  in  1  source 0 single-cycle valid strobe; no backpressure to source
- d1  in  8  source 1 (UART RX) data
- d1v  in  1  source 1 single-cycle valid strobe; no backpressure to source
- od  out  8  scheduled output byte
- odv  out  1  output valid
- odr  in  1  downstream ready
- osrc  out  1  source index of the current od
- ovf0  out  1  sticky: source 0 dropped a byte
- ovf1  out  1  sticky: source 1 dropped a byte
- drop0  out  8  saturating drop count, source 0
- drop1  out  8  saturating drop count, source 1
- clr_stats  in  1  one-cycle pulse; clears ovf0/1 and drop0/1
- busy  out  1  high when FSM is not IDLE or either FIFO is non-empty

Behaviour:
- Reset is synchronous and active-high. When asserted, on the next clk edge:
  - od=0, odv=0, osrc=0, ovf0/1=0, drop0/1=0, busy=0;
  - both FIFOs emptied; FSM set to IDLE; gap counter=0;
  - last-grant pointer set to 1, so source 0 wins the first tie.
- Reset mid-operation discards all queued bytes and any pending od without handshake.
- FIFO write:
  - dNv=1 writes dN if FIFO N is not full, or if it is full and is being popped in the same cycle (pop frees the slot).
  - Otherwise the byte is dropped: ovfN<=1, dropN<=dropN+1, saturating at 255.
  - clr_stats has priority over a same-cycle drop increment; that cycle's drop is lost from the statistics.
- FIFO: registered, DEPTH entries, pointers with an extra wrap bit. Full/empty are derived from the pointers; wrap-around is exercised by tests.
- FSM states are IDLE, SEND and GAP.
  - IDLE: if either FIFO is non-empty, grant by round-robin.
    - Both non-empty: grant the source not equal to last-grant.
    - One non-empty: grant it.
    - On grant: pop the FIFO head; od<=head, osrc<=grant, odv<=1, last-grant<=grant; go to SEND.
  - SEND: hold od, osrc and odv stable while odr=0.
    - On the cycle with odv=1 and odr=1 the transfer completes; next edge odv<=0.
    - Then go to GAP with counter=GAP_CYCLES, or to IDLE if GAP_CYCLES=0.
  - GAP: decrement the counter each cycle; at counter==1 go to IDLE. IDLE is entered after exactly GAP_CYCLES cycles.
- Latency: a strobe at edge N into an empty FIFO with FSM in IDLE gives odv=1 after edge N+2.
  - Edge N+1: write.
  - Edge N+2: pop and load od.
- Throughput: at most one byte per 2+GAP_CYCLES cycles when odr is tied high (SEND, completion, GAP, IDLE).
- odv never rises during GAP. od changes only on entry to SEND.
- Simultaneous d0v and d1v are both accepted if there is room. Order follows round-robin, not arrival.
- Per-source byte order is strictly preserved.
- busy is combinational from FSM state and FIFO empty flags.

Test Plan:
- Single byte: after reset, d0=0x41 pulse with odr=1 → od=0x41, osrc=0, odv high one cycle starting 2 cycles after the strobe; busy returns 0 after GAP_CYCLES+1 further cycles.
- Simultaneous input: d0=0x61 and d1=0x1B pulsed together, odr=1 → outputs 0x61 (osrc=0) then 0x1B (osrc=1), separated by 2+GAP_CYCLES cycles.
- Fairness: 4 bytes queued per source (0x10..0x13 on source 0, 0x20..0x23 on source 1) → output order 0x10,0x20,0x11,0x21,0x12,0x22,0x13,0x23.
- Backpressure and overflow:
  - Hold odr=0 and strobe source 1 with DEPTH+3 bytes → first byte in od, DEPTH more buffered, remaining 2 dropped: drop1=2, ovf1=1, od stable throughout.
  - Release odr → remaining bytes delivered in order.
  - clr_stats → drop1=0, ovf1=0.
- Wrap and saturation:
  - Stream 3×DEPTH bytes through source 0 with odr=1 → all delivered in order.
  - 300 drops on full source 0 → drop0 saturates at 255.
- Reset mid-SEND: assert reset while odv=1 with 3 bytes queued → next cycle odv=0, busy=0; a byte strobed after reset is the next output.
